// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a circular byte FIFO.
// Define UART_TX_PARITY_EN to add a parity bit whose sense is set by PARITY_ODD.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_Tx_DV,
  input  logic [7:0]                   i_Tx_Byte,
  output logic                         o_Tx_Ready,
  output logic                         o_Tx_Serial,
  output logic                         o_Tx_Active,
  output logic                         o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]  o_Fifo_Level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
  logic unused_parity;
  assign unused_parity = (PARITY_ODD != 0);
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          push;
  logic          pop;

  assign o_Tx_Ready   = (level != FULL);
  assign o_Fifo_Level = level;
  assign push         = i_Tx_DV && o_Tx_Ready;

  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= i_Tx_Byte;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic [7:0]    data;
  logic [7:0]    data_n;
  logic          serial;
  logic          serial_n;
  logic          tick;
  logic          have;

  assign tick = (cnt == LAST);
  assign have = (level != '0);

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
  assign parity_bit = (^data) ^ (PARITY_ODD != 0);
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      data    <= '0;
      serial  <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      data    <= data_n;
      serial  <= serial_n;
    end
  end

  // The end of STOP reloads straight into START so frames abut.
  always_comb begin
    state_n  = state;
    cnt_n    = tick ? '0 : cnt + CW'(1);
    bit_n    = bit_idx;
    data_n   = data;
    serial_n = serial;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n    = '0;
        serial_n = 1'b1;
        if (have) begin
          pop      = 1'b1;
          data_n   = mem[rd_ptr];
          serial_n = 1'b0;
          state_n  = START;
        end
      end
      START: begin
        if (tick) begin
          state_n  = DATA;
          bit_n    = '0;
          serial_n = data[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n  = PARITY;
            serial_n = parity_bit;
`else
            state_n  = STOP;
            serial_n = 1'b1;
`endif
          end else begin
            bit_n    = bit_idx + 3'd1;
            serial_n = data[bit_n];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_n  = STOP;
          serial_n = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (have) begin
            pop      = 1'b1;
            data_n   = mem[rd_ptr];
            serial_n = 1'b0;
            state_n  = START;
          end else begin
            state_n  = IDLE;
            serial_n = 1'b1;
          end
        end
      end
      default: begin
        state_n  = IDLE;
        serial_n = 1'b1;
      end
    endcase
  end

  always_comb begin
    o_Tx_Active = (state != IDLE);
    o_Tx_Done   = (state == STOP) && tick;
  end

  assign o_Tx_Serial = serial;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: bytes are queued as expected values when written; a line
// monitor decodes each frame mid-bit and pops the queue to compare.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int PODD  = 0;
  localparam int HALF  = CPB / 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam int LOW0  = (PODD == 0) ? 40 : 36;
`else
  localparam int NBITS = 10;
  localparam int LOW0  = 36;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       ready;
  logic       serial;
  logic       active;
  logic       done;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  logic [7:0] exp_q[$];
  int done_q[$];

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH),
    .PARITY_ODD(PODD)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .i_Tx_DV(dv),
    .i_Tx_Byte(tx_byte),
    .o_Tx_Ready(ready),
    .o_Tx_Serial(serial),
    .o_Tx_Active(active),
    .o_Tx_Done(done),
    .o_Fifo_Level(level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_q.push_back(ecnt);
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step(input int n, inout bit ab);
    repeat (n) begin
      if (!ab) begin
        @(negedge clk);
        if (rst) ab = 1'b1;
      end
    end
  endtask

  initial begin : monitor
    logic [7:0] got;
    logic [7:0] want;
    bit ab;
    bit st;
    bit sp;
`ifdef UART_TX_PARITY_EN
    bit pb;
`endif
    forever begin
      while (serial !== 1'b0 || rst) @(negedge clk);
      ab = 1'b0;
      got = 8'h00;
      step(HALF, ab);
      st = serial;
      for (int i = 0; i < 8; i++) begin
        step(CPB, ab);
        got[i] = serial;
      end
`ifdef UART_TX_PARITY_EN
      step(CPB, ab);
      pb = serial;
`endif
      step(CPB, ab);
      sp = serial;
      if (!ab) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected got 0x%02h want none", got);
        end else begin
          want = exp_q.pop_front();
          chk("sb_start", int'(st), 0);
          chk("sb_data", int'(got), int'(want));
`ifdef UART_TX_PARITY_EN
          chk("sb_parity", int'(pb), int'(^want) ^ PODD);
`endif
          chk("sb_stop", int'(sp), 1);
        end
      end
      step(CPB - HALF, ab);
    end
  end

  task automatic send(input logic [7:0] b);
    dv = 1'b1;
    tx_byte = b;
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    dv = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    repeat (2 * CPB) @(posedge clk);
    #1;
  endtask

  initial begin : main
    int t0;
    int lo;
    int act;
    int dn;
    int dt;
    int acc;
    int hi;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_serial", int'(serial), 1);
    chk("rst_active", int'(active), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ready", int'(ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single 0x00 frame: line, active and done timing
    send(8'h00);
    lo = 0; act = 0; dn = 0; dt = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (serial == 1'b0) lo++;
      if (active == 1'b1) act++;
      if (done == 1'b1) begin
        dn++;
        dt = i;
      end
    end
    chk("t1_low_clocks", lo, LOW0);
    chk("t1_active_clocks", act, FRAME);
    chk("t1_done_count", dn, 1);
    chk("t1_done_clock", dt, FRAME);
    drain("t1");

    // 0x55 pattern and write-to-line latency
    send(8'h55);
    @(negedge clk);
    chk("t2_level_queued", int'(level), 1);
    chk("t2_idle_before", int'(serial), 1);
    @(negedge clk);
    chk("t2_level_popped", int'(level), 0);
    chk("t2_line_low", int'(serial), 0);
    drain("t2");
    send(8'h07);
    drain("t2b");

    // four back-to-back frames
    done_q.delete();
    send(8'h00);
    t0 = ecnt;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    drain("t3");
    chk("t3_done_count", done_q.size(), 4);
    for (int i = 0; i < done_q.size() && i < 4; i++)
      chk("t3_done_time", done_q[i] - t0, FRAME * (i + 1));

    // overfill: nine accepted, the rest dropped
    done_q.delete();
    for (int k = 0; k < 9; k++) exp_q.push_back(8'(k));
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      dv = 1'b1;
      tx_byte = 8'(k);
      @(negedge clk);
      if (ready == 1'b1) acc++;
      @(posedge clk);
      #1;
    end
    dv = 1'b0;
    @(negedge clk);
    chk("t4_accepted", acc, 9);
    chk("t4_level_full", int'(level), 8);
    chk("t4_ready_low", int'(ready), 0);
    drain("t4");
    chk("t4_frames", done_q.size(), 9);

    // reset during the DATA state of the first frame
    done_q.delete();
    send(8'hFF);
    send(8'hA5);
    repeat (13) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_line_high", int'(serial), 1);
    chk("t5_level", int'(level), 0);
    chk("t5_active", int'(active), 0);
    chk("t5_ready", int'(ready), 1);
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (serial == 1'b1 && active == 1'b0) hi++;
    end
    chk("t5_idle_after", hi, 100);
    chk("t5_no_done", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
